bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter that shares the CPU's 8-bit internal bus among up to eight requesters. Its registered `slct` output drives the 3-bit select of `mux_8way`, so exactly one source's byte reaches the bus at a time. The block handles request/grant handshaking, holds ownership until release, and enforces a bounded hold time so no requester can starve the others.

## Interface
- `MAX_HOLD`, default 16: maximum cycles an owner keeps the bus while another request is pending; legal range 2..256.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  request lines; bit i set means requester i wants the bus; the owner holds its bit high while it uses the bus.
- `grant`  output  8  registered, one-hot or all-zero; bit i means requester i owns the bus.
- `slct`  output  3  registered index of the current or most recent owner; connects to `mux_8way` `slct`.
- `busy`  output  1  high while any grant is active.
- `preempt`  output  1  one-cycle pulse in the cycle after an owner is forcibly removed.

## Operation
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- State `IDLE`: no owner.
  - If `req` is nonzero, choose the first set bit scanning upward from `last+1`, wrapping 7→0. `last` is the internal 3-bit pointer to the previous owner.
  - On that edge: set `grant` to the winner, `slct` to its index, and `last` to its index; clear `hold_cnt`; go to `OWN`.
  - If `req` is zero, stay in `IDLE`.
- State `OWN`, owner `o`:
  - Release: if `req[o]` == 0, go to `IDLE` and clear `grant`.
  - Preempt: else if `hold_cnt == MAX_HOLD-1` and any other `req` bit is set, go to `IDLE`, clear `grant`, and pulse `preempt`.
  - Otherwise stay in `OWN`. `hold_cnt` increments and saturates at `MAX_HOLD-1`.
  - With no competing request, the owner keeps the bus indefinitely.
- Release takes priority over preempt when both apply on the same edge. In that case `preempt` stays 0.
- `slct` changes only on a new grant. In `IDLE` it holds the last owner's index, which keeps the mux output stable.
- `hold_cnt` width is ceil(log2(`MAX_HOLD`)). It never wraps.
- Requests on non-owner bits while in `OWN` are ignored until the next `IDLE` evaluation. Requests are level-sensitive and never latched.
- Reset values: `grant`=0, `slct`=0, `busy`=0, `preempt`=0, state=`IDLE`, `hold_cnt`=0, `last`=7, so requester 0 has top priority after reset.
- Reset mid-ownership: `grant` clears on the reset edge regardless of `req`, and the `last` pointer returns to 7.

## Timing
- Grant latency: `req` sampled high on edge k in `IDLE` → `grant` and `busy` high after edge k, i.e. visible in cycle k+1.
- Release latency: `req[o]` sampled low on edge k → `grant` low after edge k.
- Hand-off: at least one `IDLE` (bus turnaround) cycle separates consecutive owners.
  - Owner A drops `req` → 1 cycle with `grant`=0 → owner B granted.
  - Back-to-back hand-off period is therefore 2 edges.
- Maximum continuous ownership under contention: `MAX_HOLD` cycles of `grant` high.
- Worst-case wait for a continuously requesting input: 7 × (`MAX_HOLD` + 1) cycles.
- `preempt` is high exactly during the first `IDLE` cycle following a forced removal.
- All outputs are registered. There is no combinational path from `req` to any output.

## Test plan
- Reset, then `req`=0x01 → after the next edge `grant`=0x01, `slct`=0, `busy`=1; drop `req` → `grant`=0x00 one edge later, `slct` stays 0.
- Round robin: hold `req`=0xFF, with each owner dropping its bit for one cycle after 3 cycles of ownership → grant order 0,1,2,…,7,0 with one idle cycle between owners, and `slct` matching each grant.
- Preempt, `MAX_HOLD`=4: `req`=0x05 held constant → requester 0 owns for 4 cycles, `preempt` pulses, then requester 2 owns for 4 cycles, then 0 again; no owner exceeds 4 cycles.
- Sole requester: `req`=0x10 for 100 cycles with `MAX_HOLD`=4 → `grant`=0x10 continuously and `preempt` never asserts.
- Release and preempt on the same edge: the owner drops `req` exactly when `hold_cnt`=`MAX_HOLD-1` with a competitor pending → `grant` clears and `preempt` stays 0.
- Reset mid-ownership: requester 5 owns, assert `reset` for 1 cycle with `req`=0x21 held → `grant`=0 after the reset edge, then requester 0 is granted (`last`=7).

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter sharing the CPU's 8-bit internal bus among up to eight
// requesters. The registered slct output drives the 3-bit select of mux_8way,
// so exactly one source's byte reaches the bus at a time. An owner keeps the
// bus until it drops its request, or until it has held the bus for MAX_HOLD
// cycles while another requester is waiting.
//
// Parameters
//   MAX_HOLD  maximum cycles an owner keeps the bus under contention (2..256)
//
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high reset
//   req      in   8  level-sensitive request lines, bit i = requester i
//   grant    out  8  registered one-hot (or zero) grant
//   slct     out  3  registered index of the current or most recent owner
//   busy     out  1  registered, high while any grant is active
//   preempt  out  1  one-cycle pulse in the first idle cycle after a forced
//                    removal
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] slct,
  output logic       busy,
  output logic       preempt
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [7:0]        r_grant;
  logic [2:0]        r_slct;
  logic [2:0]        r_last;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_busy;
  logic              r_preempt;

  state_t            w_nxt_state;
  logic [7:0]        w_nxt_grant;
  logic [2:0]        w_nxt_slct;
  logic [2:0]        w_nxt_last;
  logic [HOLD_W-1:0] w_nxt_hold_cnt;
  logic              w_nxt_preempt;

  logic              w_found;
  logic [2:0]        w_winner;
  logic [2:0]        w_idx;
  logic              w_owner_req;
  logic              w_others;

  // Round-robin search: first set request scanning upward from last+1,
  // wrapping 7->0. The 3-bit add wraps naturally; k=8 revisits last itself.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = '0;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_last + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // In OWN, slct always holds the owner's index.
  assign w_owner_req = req[r_slct];
  assign w_others    = |(req & ~r_grant);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_grant    = r_grant;
    w_nxt_slct     = r_slct;
    w_nxt_last     = r_last;
    w_nxt_hold_cnt = r_hold_cnt;
    w_nxt_preempt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state    = OWN;
          w_nxt_grant    = 8'(1) << w_winner;
          w_nxt_slct     = w_winner;
          w_nxt_last     = w_winner;
          w_nxt_hold_cnt = '0;
        end
      end
      OWN: begin
        // Release wins over preempt, so a voluntary drop never pulses preempt.
        if (!w_owner_req) begin
          w_nxt_state = IDLE;
          w_nxt_grant = '0;
        end else if (r_hold_cnt == HOLD_LAST && w_others) begin
          w_nxt_state   = IDLE;
          w_nxt_grant   = '0;
          w_nxt_preempt = 1'b1;
        end else if (r_hold_cnt != HOLD_LAST) begin
          // Saturates so a sole requester can hold indefinitely without wrap.
          w_nxt_hold_cnt = r_hold_cnt + 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_slct     <= '0;
      r_last     <= 3'd7;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_slct     <= w_nxt_slct;
      r_last     <= w_nxt_last;
      r_hold_cnt <= w_nxt_hold_cnt;
      r_busy     <= |w_nxt_grant;
      r_preempt  <= w_nxt_preempt;
    end
  end

  assign grant   = r_grant;
  assign slct    = r_slct;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule
